// File: rtl/decode_operand_stage_pkg.sv
// Shared definitions for the decode/operand stage of the multi-cycle RV32I core:
// datapath width, register count, supported opcodes, FSM state type and
// immediate-extension helpers.
package decode_operand_stage_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NREGS  = 32;
  localparam int unsigned REG_AW = $clog2(NREGS);

  localparam logic [6:0] ITYPE   = 7'b0010011;
  localparam logic [6:0] J_ITYPE = 7'b1100111;
  localparam logic [6:0] RTYPE   = 7'b0110011;
  localparam logic [6:0] BTYPE   = 7'b1100011;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRead  = 2'd1,
    StIssue = 2'd2
  } state_e;

  // I-type immediate, sign taken from instr[31] only.
  function automatic logic [XLEN-1:0] imm_i(input logic [31:0] instr);
    return {{(XLEN-12){instr[31]}}, instr[31:20]};
  endfunction

  // B-type branch offset (always even).
  function automatic logic [XLEN-1:0] imm_b(input logic [31:0] instr);
    return {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/decode_operand_stage_if.sv
// Signal bundle around the decode/operand stage.
//   fetch side : instr_valid, instr_ready, instr, pc
//   writeback  : wb_en, wb_rd, wb_data
//   ALU side   : ex_valid, ex_ready, opcode, func3, func7, func7_vld,
//                op1, op2, rs2_data, rd, pc_out, illegal
// master = the surrounding core (fetch, writeback, execute); slave = the stage.
interface decode_operand_stage_if;
  import decode_operand_stage_pkg::*;

  logic                instr_valid;
  logic                instr_ready;
  logic [31:0]         instr;
  logic [XLEN-1:0]     pc;

  logic                wb_en;
  logic [REG_AW-1:0]   wb_rd;
  logic [XLEN-1:0]     wb_data;

  logic                ex_valid;
  logic                ex_ready;
  logic [6:0]          opcode;
  logic [2:0]          func3;
  logic                func7;
  logic                func7_vld;
  logic [XLEN-1:0]     op1;
  logic [XLEN-1:0]     op2;
  logic [XLEN-1:0]     rs2_data;
  logic [4:0]          rd;
  logic [XLEN-1:0]     pc_out;
  logic                illegal;

  modport master (
    output instr_valid, instr, pc, wb_en, wb_rd, wb_data, ex_ready,
    input  instr_ready, ex_valid, opcode, func3, func7, func7_vld,
           op1, op2, rs2_data, rd, pc_out, illegal
  );

  modport slave (
    input  instr_valid, instr, pc, wb_en, wb_rd, wb_data, ex_ready,
    output instr_ready, ex_valid, opcode, func3, func7, func7_vld,
           op1, op2, rs2_data, rd, pc_out, illegal
  );

endinterface

// File: rtl/decode_operand_stage_reg_file.sv
// Architectural register file: NREGS x XLEN, two asynchronous read ports,
// one synchronous write port, asynchronous clear. x0 always reads zero and
// ignores writes. No bypassing here; the stage adds it around the read ports.
//   clk, rst_n      : clock, asynchronous active-low clear
//   raddr1/rdata1   : read port 1
//   raddr2/rdata2   : read port 2
//   we/waddr/wdata  : write port
module decode_operand_stage_reg_file
  import decode_operand_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] raddr1,
  output logic [XLEN-1:0]   rdata1,
  input  logic [REG_AW-1:0] raddr2,
  output logic [XLEN-1:0]   rdata2,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [XLEN-1:0]   wdata
);

  logic [XLEN-1:0] regs_q [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      regs_q[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == '0) ? '0 : regs_q[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : regs_q[raddr2];

endmodule

// File: rtl/decode_operand_stage.sv
// Decode/operand stage feeding the ALU of the multi-cycle RV32I core.
// Accepts an instruction and its PC, reads rs1/rs2 (with write-first bypass
// from the writeback port), builds the immediate, selects op1/op2 and holds
// the registered result for the ALU until ex_ready. Owns the register file.
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : slave side of decode_operand_stage_if (fetch, writeback, ALU)
// Flow: IDLE (accept) -> READ (read + decode, register outputs) -> ISSUE.
module decode_operand_stage
  import decode_operand_stage_pkg::*;
(
  input logic                  clk,
  input logic                  rst_n,
  decode_operand_stage_if.slave bus
);

  state_e state_q, state_d;
  logic   accept, load;

  logic [31:0]     instr_q;
  logic [XLEN-1:0] pc_q;

  logic [6:0]      opcode_q,   opcode_d;
  logic [2:0]      func3_q,    func3_d;
  logic            func7_q,    func7_d;
  logic            func7_vld_q, func7_vld_d;
  logic [XLEN-1:0] op1_q,      op1_d;
  logic [XLEN-1:0] op2_q,      op2_d;
  logic [XLEN-1:0] rs2_data_q, rs2_data_d;
  logic [4:0]      rd_q,       rd_d;
  logic            illegal_q,  illegal_d;

  logic [REG_AW-1:0] rs1_idx, rs2_idx;
  logic [XLEN-1:0]   rf_rdata1, rf_rdata2;
  logic [XLEN-1:0]   rs1_val, rs2_val;
  logic              shift_imm;

  // FSM next state
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.instr_valid) begin
          accept  = 1'b1;
          state_d = StRead;
        end
      end
      StRead: begin
        load    = 1'b1;
        state_d = StIssue;
      end
      StIssue: begin
        if (bus.ex_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.instr_ready = (state_q == StIdle);
  assign bus.ex_valid    = (state_q == StIssue);

  assign rs1_idx = instr_q[19:15];
  assign rs2_idx = instr_q[24:20];

  decode_operand_stage_reg_file u_reg_file (
    .clk    (clk),
    .rst_n  (rst_n),
    .raddr1 (rs1_idx),
    .rdata1 (rf_rdata1),
    .raddr2 (rs2_idx),
    .rdata2 (rf_rdata2),
    .we     (bus.wb_en),
    .waddr  (bus.wb_rd),
    .wdata  (bus.wb_data)
  );

  // Write-first bypass: a write landing on the same edge that captures the
  // operands must be visible. x0 is never bypassed.
  assign rs1_val = (bus.wb_en && (bus.wb_rd == rs1_idx) && (rs1_idx != '0)) ?
                   bus.wb_data : rf_rdata1;
  assign rs2_val = (bus.wb_en && (bus.wb_rd == rs2_idx) && (rs2_idx != '0)) ?
                   bus.wb_data : rf_rdata2;

  // SLLI/SRLI/SRAI take a 5-bit shamt; func7[5] selects SRAI vs SRLI.
  assign shift_imm = (instr_q[14:12] == 3'b001) || (instr_q[14:12] == 3'b101);

  // Decode and operand select
  always_comb begin
    opcode_d    = instr_q[6:0];
    func3_d     = instr_q[14:12];
    func7_vld_d = 1'b0;
    rd_d        = instr_q[11:7];
    rs2_data_d  = rs2_val;
    illegal_d   = 1'b0;
    op1_d       = rs1_val;
    op2_d       = '0;
    case (instr_q[6:0])
      RTYPE: begin
        op2_d       = rs2_val;
        func7_vld_d = 1'b1;
      end
      ITYPE: begin
        if (shift_imm) begin
          op2_d       = {{(XLEN-5){1'b0}}, instr_q[24:20]};
          func7_vld_d = 1'b1;
        end else begin
          op2_d = imm_i(instr_q);
        end
      end
      J_ITYPE: begin
        op2_d = imm_i(instr_q);
      end
      BTYPE: begin
        op1_d = pc_q;
        op2_d = imm_b(instr_q);
        rd_d  = '0;
      end
      default: begin
        illegal_d = 1'b1;
        op1_d     = '0;
        op2_d     = '0;
      end
    endcase
    func7_d = func7_vld_d & instr_q[30];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      instr_q     <= '0;
      pc_q        <= '0;
      opcode_q    <= '0;
      func3_q     <= '0;
      func7_q     <= 1'b0;
      func7_vld_q <= 1'b0;
      op1_q       <= '0;
      op2_q       <= '0;
      rs2_data_q  <= '0;
      rd_q        <= '0;
      illegal_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        instr_q <= bus.instr;
        pc_q    <= bus.pc;
      end
      // Outputs only change on the READ edge, so they stay frozen while stalled.
      if (load) begin
        opcode_q    <= opcode_d;
        func3_q     <= func3_d;
        func7_q     <= func7_d;
        func7_vld_q <= func7_vld_d;
        op1_q       <= op1_d;
        op2_q       <= op2_d;
        rs2_data_q  <= rs2_data_d;
        rd_q        <= rd_d;
        illegal_q   <= illegal_d;
      end
    end
  end

  assign bus.opcode    = opcode_q;
  assign bus.func3     = func3_q;
  assign bus.func7     = func7_q;
  assign bus.func7_vld = func7_vld_q;
  assign bus.op1       = op1_q;
  assign bus.op2       = op2_q;
  assign bus.rs2_data  = rs2_data_q;
  assign bus.rd        = rd_q;
  assign bus.pc_out    = pc_q;
  assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_decode_operand_stage.sv
// Scoreboard bench for decode_operand_stage: the driver pushes the expected
// ALU bundle (from a behavioural decode model and a shadow register array)
// when an instruction reaches READ; a negedge monitor compares while ex_valid
// is high and pops on ex_ready.
module tb_decode_operand_stage;
  import decode_operand_stage_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  decode_operand_stage_if bus ();

  decode_operand_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic        func7;
    logic        func7_vld;
    logic        illegal;
    logic [4:0]  rd;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] rs2_data;
    logic [31:0] pc;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] mregs [32];

  // directed writeback traffic during READ (bp_*) and during ISSUE stalls (st_*)
  logic        bp_en = 0, st_en = 0;
  logic [4:0]  bp_rd = 0, st_rd = 0;
  logic [31:0] bp_data = 0, st_data = 0;

  // Shadow register file: what software would see after each committed write.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) mregs[i] <= '0;
    end else if (bus.wb_en && bus.wb_rd != 0) begin
      mregs[bus.wb_rd] <= bus.wb_data;
    end
  end

  always @(negedge rst_n) sb_q.delete();

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  // Value a read of register r returns in the current cycle (write-first).
  function automatic logic [31:0] reg_value(input logic [4:0] r);
    if (r == 0) return 32'd0;
    if (bus.wb_en && bus.wb_rd == r) return bus.wb_data;
    return mregs[r];
  endfunction

  function automatic exp_t ref_decode(input logic [31:0] i, input logic [31:0] p,
                                      input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   immi, immb;
    immi = int'(i[31:20]);
    if (i[31]) immi = immi - 4096;
    immb = int'({i[31], i[7], i[30:25], i[11:8], 1'b0});
    if (i[31]) immb = immb - 8192;
    e.opcode    = i[6:0];
    e.func3     = i[14:12];
    e.func7_vld = 1'b0;
    e.illegal   = 1'b0;
    e.rd        = i[11:7];
    e.rs2_data  = b;
    e.pc        = p;
    e.op1       = a;
    e.op2       = 32'd0;
    if (i[6:0] == RTYPE) begin
      e.op2 = b;
      e.func7_vld = 1'b1;
    end else if (i[6:0] == ITYPE && (i[14:12] == 3'd1 || i[14:12] == 3'd5)) begin
      e.op2 = 32'(i[24:20]);
      e.func7_vld = 1'b1;
    end else if (i[6:0] == ITYPE || i[6:0] == J_ITYPE) begin
      e.op2 = 32'(immi);
    end else if (i[6:0] == BTYPE) begin
      e.op1 = p;
      e.op2 = 32'(immb);
      e.rd  = 5'd0;
    end else begin
      e.illegal = 1'b1;
      e.op1 = 32'd0;
    end
    e.func7 = e.func7_vld ? i[30] : 1'b0;
    return e;
  endfunction

  // Monitor
  always @(negedge clk) begin
    exp_t act;
    if (rst_n && bus.ex_valid) begin
      act.opcode    = bus.opcode;
      act.func3     = bus.func3;
      act.func7     = bus.func7;
      act.func7_vld = bus.func7_vld;
      act.illegal   = bus.illegal;
      act.rd        = bus.rd;
      act.op1       = bus.op1;
      act.op2       = bus.op2;
      act.rs2_data  = bus.rs2_data;
      act.pc        = bus.pc_out;
      chk("instr_ready_in_issue", bus.instr_ready, 0);
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ex_valid: got bundle %0h, expected none", act);
      end else begin
        chk("ex_bundle", act, sb_q[0]);
        if (bus.ex_ready) void'(sb_q.pop_front());
      end
    end
  end

  task automatic rand_wb(input logic [31:0] ins);
    int sel;
    sel = $urandom_range(0, 3);
    bus.wb_en   = 1'($urandom_range(0, 1));
    bus.wb_rd   = (sel == 0) ? ins[19:15] : (sel == 1) ? ins[24:20] :
                  (sel == 2) ? 5'd0 : 5'($urandom);
    bus.wb_data = $urandom;
  endtask

  task automatic wb_write(input logic [4:0] r, input logic [31:0] d);
    bus.wb_en = 1'b1;
    bus.wb_rd = r;
    bus.wb_data = d;
    @(posedge clk); #1;
    bus.wb_en = 1'b0;
  endtask

  // Runs one instruction through IDLE/READ/ISSUE; called at posedge+1.
  task automatic issue(input logic [31:0] ins, input logic [31:0] p, input bit rnd,
                       input int stall);
    int guard;
    guard = 0;
    while (!bus.instr_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("instr_ready_idle", bus.instr_ready, 1);
    chk("ex_valid_idle", bus.ex_valid, 0);
    bus.instr_valid = 1'b1;
    bus.instr = ins;
    bus.pc = p;
    bus.ex_ready = 1'($urandom_range(0, 1));
    if (rnd) rand_wb(ins);
    else bus.wb_en = 1'b0;
    @(posedge clk); #1;  // READ
    chk("ex_valid_read", bus.ex_valid, 0);
    chk("instr_ready_read", bus.instr_ready, 0);
    bus.instr_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
    bus.instr = $urandom;
    bus.pc = $urandom;
    bus.ex_ready = 1'($urandom_range(0, 1));
    if (rnd) begin
      rand_wb(ins);
    end else begin
      bus.wb_en = bp_en;
      bus.wb_rd = bp_rd;
      bus.wb_data = bp_data;
    end
    sb_q.push_back(ref_decode(ins, p, reg_value(ins[19:15]), reg_value(ins[24:20])));
    @(posedge clk); #1;  // ISSUE
    chk("ex_valid_issue", bus.ex_valid, 1);
    for (int k = 0; k <= stall; k++) begin
      bus.ex_ready = (k == stall);
      bus.instr_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      if (rnd) begin
        rand_wb(ins);
      end else begin
        bus.wb_en = st_en;
        bus.wb_rd = st_rd;
        bus.wb_data = st_data;
      end
      @(posedge clk); #1;
    end
    bus.ex_ready = 1'b0;
    bus.instr_valid = 1'b0;
    bus.wb_en = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] ops [5];
    logic [31:0] ins;
    ops[0] = RTYPE; ops[1] = ITYPE; ops[2] = J_ITYPE; ops[3] = BTYPE; ops[4] = 7'h37;
    bus.instr_valid = 0; bus.instr = 0; bus.pc = 0;
    bus.wb_en = 0; bus.wb_rd = 0; bus.wb_data = 0; bus.ex_ready = 0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_instr_ready", bus.instr_ready, 1);
    chk("reset_ex_valid", bus.ex_valid, 0);
    chk("reset_op1", bus.op1, 0);
    chk("reset_op2", bus.op2, 0);
    chk("reset_opcode", bus.opcode, 0);
    chk("reset_pc_out", bus.pc_out, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // RTYPE add x3,x1,x2
    wb_write(5'd1, 32'd7);
    wb_write(5'd2, 32'd9);
    issue(32'h002081B3, 32'h40, 0, 0);
    // ITYPE addi x4,x1,-1 and srai x4,x1,3
    wb_write(5'd1, 32'h10);
    issue(32'hFFF08213, 32'h44, 0, 1);
    issue(32'h4030D213, 32'h48, 0, 0);
    // BTYPE beq x1,x2,-8 at 0x100
    issue(32'hFE208CE3, 32'h100, 0, 0);
    // bypass x1=0xAB during READ, then stall 5 cycles while writing x1=0xCD
    bp_en = 1; bp_rd = 5'd1; bp_data = 32'hAB;
    st_en = 1; st_rd = 5'd1; st_data = 32'hCD;
    issue(32'h002081B3, 32'h200, 0, 5);
    bp_en = 0; st_en = 0;
    // illegal opcode 0x37
    issue(32'h000552B7, 32'h300, 0, 0);
    // x0 ignores writes
    wb_write(5'd0, 32'h55);
    issue(32'h000003B3, 32'h304, 0, 0);

    // reset in the middle of ISSUE
    wb_write(5'd5, 32'h99);
    bus.instr_valid = 1'b1;
    bus.instr = 32'h00528333;
    bus.pc = 32'h400;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    sb_q.push_back(ref_decode(32'h00528333, 32'h400, reg_value(5'd5), reg_value(5'd5)));
    @(posedge clk); #1;
    chk("pre_reset_ex_valid", bus.ex_valid, 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_ex_valid", bus.ex_valid, 0);
    chk("midreset_instr_ready", bus.instr_ready, 1);
    chk("midreset_op1", bus.op1, 0);
    chk("midreset_op2", bus.op2, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    // x5 was cleared by reset
    issue(32'h00528333, 32'h404, 0, 0);

    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      ins = $urandom;
      ins[6:0] = ops[$urandom_range(0, 4)];
      issue(ins, $urandom, 1, $urandom_range(0, 3));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
